rename_ctrl: RTL
================

Name: rename_ctrl

Overview:
- Rename/allocate sequencer between decode and dispatch for the 4-wide Data-in-ROB backend.
- Accepts up to 4 decoded instructions per cycle and allocates consecutive ROB indices from a tail pointer with a free-entry counter.
- Drives the speculative RAT read and write ports and resolves intra-group RAW dependences, which the RAT cannot see in the same cycle.
- Registers the renamed group toward dispatch behind a valid/ready handshake.

Parameters:
- ROB_DEPTH, 64, number of ROB entries; must be a power of 2.
- ROB_IDX_WIDTH, $clog2(ROB_DEPTH), ROB tag width.
- CNT_WIDTH, $clog2(ROB_DEPTH)+1, free-counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  mispredict/exception flush
- in_valid_i  in  4  per-slot valid; slot 0 is oldest
- in_ready_o  out  1  group accepted when high
- in_rs1_idx_i / in_rs2_idx_i  in  4x5  source areg
- in_rd_we_i  in  4  slot writes rd
- in_rd_idx_i  in  4x5  dest areg
- rat_rs1_idx_o / rat_rs2_idx_o  out  4x5  RAT read address (= in_rs*_idx_i)
- rat_rs1_in_rob_i / rat_rs2_in_rob_i  in  4  RAT lookup result
- rat_rs1_rob_idx_i / rat_rs2_rob_idx_i  in  4xROB_IDX_WIDTH  RAT tag
- rat_disp_we_o  out  4  RAT write enable
- rat_disp_rd_idx_o  out  4x5  RAT write areg
- rat_disp_rob_idx_o  out  4xROB_IDX_WIDTH  RAT write tag
- commit_cnt_i  in  3  ROB entries retired this cycle, 0..4
- out_valid_o  out  4  renamed slot valid
- out_ready_i  in  1  dispatch accepts group
- out_rob_idx_o  out  4xROB_IDX_WIDTH  allocated ROB index
- out_rs1_in_rob_o / out_rs2_in_rob_o  out  4  source pending in ROB
- out_rs1_rob_idx_o / out_rs2_rob_idx_o  out  4xROB_IDX_WIDTH  source tag
- out_rd_we_o  out  4  registered in_rd_we_i
- out_rd_idx_o  out  4x5  registered in_rd_idx_i
- rob_tail_o  out  ROB_IDX_WIDTH  current tail
- rob_free_cnt_o  out  CNT_WIDTH  free ROB entries

Behaviour:
- Reset values: tail=0, free=ROB_DEPTH, out_valid_o=0, all out_* data=0.
- out_free = (out_valid_o==0) | out_ready_i.
- in_ready_o = out_free & (free >= 4) & !flush_i. No combinational dependence on in_valid_i.
- fire = in_ready_o & |in_valid_i.
- alloc_cnt = popcount(in_valid_i) when fire, else 0.
- Slot i ROB index = tail + popcount(in_valid_i[i-1:0]), modulo ROB_DEPTH. Invalid slots consume no index. Any valid pattern is legal.
- Clock edge on fire or commit: tail <= tail + alloc_cnt (wraps); free <= free - alloc_cnt + commit_cnt_i. free never exceeds ROB_DEPTH; a commit that would overflow it is a checker error.
- RAT write: rat_disp_we_o[i] = fire & in_valid_i[i] & in_rd_we_i[i] & (in_rd_idx_i[i]!=0). rat_disp_rob_idx_o[i] = slot i ROB index. Writes take effect combinationally and are visible to the RAT at the same edge as the output register load.
- Intra-group bypass, per slot i and source s with idx!=0: take the youngest j<i with in_valid_i[j] & in_rd_we_i[j] & in_rd_idx_i[j]==idx. On a match: in_rob=1, tag=slot j ROB index. Otherwise use the RAT result. idx==0 gives in_rob=0, tag=0.
- Output register, 1-cycle latency:
  - On fire: all out_* load and out_valid_o <= in_valid_i.
  - Else if out_ready_i: out_valid_o <= 0.
  - Else: hold all out_* unchanged.
- flush_i has priority over all other events:
  - Next cycle: out_valid_o=0, tail=0, free=ROB_DEPTH.
  - commit_cnt_i is ignored in the flush cycle.
  - rat_disp_we_o=0 during the flush cycle.
  - The ROB resets its head and tail to 0 on flush_i by contract.
- Reset asserted mid-operation returns every state element to its reset value immediately.
- Wrap-around: the ROB index sequence continues modulo ROB_DEPTH within a group, e.g. tail=62 with 4 valid slots gives 62,63,0,1.

Optional Feature:
- Macro: RENAME_CTRL_PRECISE_READY_EN.
- Defined: in_ready_o = out_free & (free >= popcount(in_valid_i)) & !flush_i. in_ready_o then depends combinationally on in_valid_i, so partial groups can fill the last 1-3 ROB entries.
- Undefined: the conservative free >= 4 rule applies.

Test Plan:
- Reset, then 4 valid slots with rd=1,2,3,4 and free=64 -> out_rob_idx 0,1,2,3 next cycle; tail=4; free=60; rat_disp_we=1111.
- Group where slot0 writes x5 and slots 2 and 3 read x5 as rs1; RAT reports x5 in ARF -> slots 2 and 3 get out_rs1_in_rob=1 and tag=slot0 index. Slot1 also writes x5 -> slot 3 gets slot1's tag.
- Advance tail to 62, then in_valid=1111 -> out_rob_idx 62,63,0,1; tail=2.
- Fill to free=3 -> in_ready_o=0. Apply commit_cnt=2 -> free=5 and in_ready_o=1. With the macro defined and free=3, in_valid=0011 is accepted.
- Hold out_ready_i=0 with out_valid set -> out_* stable and in_ready_o=0. Then out_ready_i=1 with a new group -> back-to-back transfer with no bubble.
- flush_i in the same cycle as a valid group and commit_cnt=3 -> no RAT write; next cycle tail=0, free=64, out_valid=0.

Source files
------------

// File: rtl/rename_ctrl.sv
// Rename/allocate sequencer: ROB index allocation, RAT port drive, intra-group RAW bypass.
// Optional macro RENAME_CTRL_PRECISE_READY_EN: admit partial groups down to the last free entries.
module rename_ctrl #(
  parameter int unsigned ROB_DEPTH     = 64,
  parameter int unsigned ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
  parameter int unsigned CNT_WIDTH     = $clog2(ROB_DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [3:0]                    in_valid_i,
  output logic                          in_ready_o,
  input  logic [3:0][4:0]               in_rs1_idx_i,
  input  logic [3:0][4:0]               in_rs2_idx_i,
  input  logic [3:0]                    in_rd_we_i,
  input  logic [3:0][4:0]               in_rd_idx_i,
  output logic [3:0][4:0]               rat_rs1_idx_o,
  output logic [3:0][4:0]               rat_rs2_idx_o,
  input  logic [3:0]                    rat_rs1_in_rob_i,
  input  logic [3:0]                    rat_rs2_in_rob_i,
  input  logic [3:0][ROB_IDX_WIDTH-1:0] rat_rs1_rob_idx_i,
  input  logic [3:0][ROB_IDX_WIDTH-1:0] rat_rs2_rob_idx_i,
  output logic [3:0]                    rat_disp_we_o,
  output logic [3:0][4:0]               rat_disp_rd_idx_o,
  output logic [3:0][ROB_IDX_WIDTH-1:0] rat_disp_rob_idx_o,
  input  logic [2:0]                    commit_cnt_i,
  output logic [3:0]                    out_valid_o,
  input  logic                          out_ready_i,
  output logic [3:0][ROB_IDX_WIDTH-1:0] out_rob_idx_o,
  output logic [3:0]                    out_rs1_in_rob_o,
  output logic [3:0]                    out_rs2_in_rob_o,
  output logic [3:0][ROB_IDX_WIDTH-1:0] out_rs1_rob_idx_o,
  output logic [3:0][ROB_IDX_WIDTH-1:0] out_rs2_rob_idx_o,
  output logic [3:0]                    out_rd_we_o,
  output logic [3:0][4:0]               out_rd_idx_o,
  output logic [ROB_IDX_WIDTH-1:0]      rob_tail_o,
  output logic [CNT_WIDTH-1:0]          rob_free_cnt_o
);

  logic [ROB_IDX_WIDTH-1:0]      tail_q;
  logic [CNT_WIDTH-1:0]          free_q;
  logic [3:0]                    out_valid_q;
  logic [3:0][ROB_IDX_WIDTH-1:0] out_rob_idx_q;
  logic [3:0]                    out_rs1_in_rob_q, out_rs2_in_rob_q;
  logic [3:0][ROB_IDX_WIDTH-1:0] out_rs1_rob_idx_q, out_rs2_rob_idx_q;
  logic [3:0]                    out_rd_we_q;
  logic [3:0][4:0]               out_rd_idx_q;

  logic [3:0][ROB_IDX_WIDTH-1:0] slot_idx;
  logic [2:0]                    valid_cnt;
  logic [2:0]                    alloc_cnt;
  logic                          out_free, room, fire;
  logic [3:0]                    rs1_in_rob, rs2_in_rob;
  logic [3:0][ROB_IDX_WIDTH-1:0] rs1_tag, rs2_tag;
  logic [CNT_WIDTH:0]            free_sum;

  // Each slot takes tail plus the number of valid older slots; invalid slots take no index.
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      slot_idx[i] = tail_q + ROB_IDX_WIDTH'(valid_cnt);
      valid_cnt   = valid_cnt + {2'b00, in_valid_i[i]};
    end
  end

  assign out_free = ~(|out_valid_q) | out_ready_i;

`ifdef RENAME_CTRL_PRECISE_READY_EN
  assign room = 32'(free_q) >= 32'(valid_cnt);
`else
  assign room = 32'(free_q) >= 32'd4;
`endif

  assign in_ready_o = out_free & room & ~flush_i;
  assign fire       = in_ready_o & (|in_valid_i);
  assign alloc_cnt  = fire ? valid_cnt : 3'd0;

  assign rat_rs1_idx_o      = in_rs1_idx_i;
  assign rat_rs2_idx_o      = in_rs2_idx_i;
  assign rat_disp_rd_idx_o  = in_rd_idx_i;
  assign rat_disp_rob_idx_o = slot_idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rat_disp_we_o[i] = fire & in_valid_i[i] & in_rd_we_i[i] & (in_rd_idx_i[i] != 5'd0);
    end
  end

  // The RAT cannot see same-group writes; the youngest older writer overrides its answer.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rs1_in_rob[i] = rat_rs1_in_rob_i[i];
      rs1_tag[i]    = rat_rs1_rob_idx_i[i];
      rs2_in_rob[i] = rat_rs2_in_rob_i[i];
      rs2_tag[i]    = rat_rs2_rob_idx_i[i];
      for (int j = 0; j < i; j++) begin
        if (in_valid_i[j] && in_rd_we_i[j] && (in_rd_idx_i[j] == in_rs1_idx_i[i])) begin
          rs1_in_rob[i] = 1'b1;
          rs1_tag[i]    = slot_idx[j];
        end
        if (in_valid_i[j] && in_rd_we_i[j] && (in_rd_idx_i[j] == in_rs2_idx_i[i])) begin
          rs2_in_rob[i] = 1'b1;
          rs2_tag[i]    = slot_idx[j];
        end
      end
      if (in_rs1_idx_i[i] == 5'd0) begin
        rs1_in_rob[i] = 1'b0;
        rs1_tag[i]    = '0;
      end
      if (in_rs2_idx_i[i] == 5'd0) begin
        rs2_in_rob[i] = 1'b0;
        rs2_tag[i]    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tail_q            <= '0;
      free_q            <= CNT_WIDTH'(ROB_DEPTH);
      out_valid_q       <= '0;
      out_rob_idx_q     <= '0;
      out_rs1_in_rob_q  <= '0;
      out_rs2_in_rob_q  <= '0;
      out_rs1_rob_idx_q <= '0;
      out_rs2_rob_idx_q <= '0;
      out_rd_we_q       <= '0;
      out_rd_idx_q      <= '0;
    end else if (flush_i) begin
      tail_q      <= '0;
      free_q      <= CNT_WIDTH'(ROB_DEPTH);
      out_valid_q <= '0;
    end else begin
      tail_q <= tail_q + ROB_IDX_WIDTH'(alloc_cnt);
      free_q <= free_q - CNT_WIDTH'(alloc_cnt) + CNT_WIDTH'(commit_cnt_i);
      if (fire) begin
        out_valid_q       <= in_valid_i;
        out_rob_idx_q     <= slot_idx;
        out_rs1_in_rob_q  <= rs1_in_rob;
        out_rs2_in_rob_q  <= rs2_in_rob;
        out_rs1_rob_idx_q <= rs1_tag;
        out_rs2_rob_idx_q <= rs2_tag;
        out_rd_we_q       <= in_rd_we_i;
        out_rd_idx_q      <= in_rd_idx_i;
      end else if (out_ready_i) begin
        out_valid_q <= '0;
      end
    end
  end

  assign out_valid_o       = out_valid_q;
  assign out_rob_idx_o     = out_rob_idx_q;
  assign out_rs1_in_rob_o  = out_rs1_in_rob_q;
  assign out_rs2_in_rob_o  = out_rs2_in_rob_q;
  assign out_rs1_rob_idx_o = out_rs1_rob_idx_q;
  assign out_rs2_rob_idx_o = out_rs2_rob_idx_q;
  assign out_rd_we_o       = out_rd_we_q;
  assign out_rd_idx_o      = out_rd_idx_q;
  assign rob_tail_o        = tail_q;
  assign rob_free_cnt_o    = free_q;

  // Retiring more entries than are allocated is an ROB-side protocol error.
  assign free_sum = {1'b0, free_q} + (CNT_WIDTH + 1)'(commit_cnt_i)
                  - (CNT_WIDTH + 1)'(alloc_cnt);

  a_free_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !flush_i |-> (free_sum <= (CNT_WIDTH + 1)'(ROB_DEPTH)));

endmodule
